mdu_seq: RTL and testbench



---
 rtl/mips_pkg.sv | 20 ++
 rtl/mips_alu.sv | 34 +++
 rtl/mdu_seq.sv | 147 ++++++++++++++
 tb/tb_mdu_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALU controls, MDU state/op encodings,
// and the MSB-based carry helper used for both carry and borrow detection.
package mips_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {IDLE, RUN, DONE} mdu_state_t;
   typedef enum logic {MULTU = 1'b0, DIVU = 1'b1} mdu_op_t;

   // Carry out of an adder from operand and sum MSBs only. For a subtract,
   // pass the inverted b MSB and the result is the no-borrow flag.
   function automatic logic add_carry(input logic a, input logic b, input logic s);
      return (a & b) | ((a | b) & ~s);
   endfunction

endpackage

// File: rtl/mips_alu.sv
// 32-bit MIPS ALU: AND/OR/ADD/SUB/SLT, purely combinational, no carry-out.
module mips_alu
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alucont,
   output logic [WIDTH-1:0] result
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] sum;

   // Subtract is a + ~b + 1, selected by alucont[2].
   always_comb begin
      b_eff = alucont[2] ? ~b : b;
      sum   = a + b_eff + {{(WIDTH-1){1'b0}}, alucont[2]};
   end

   // Result select on the low two control bits.
   always_comb begin
      result = '0;
      unique case (alucont[1:0])
         2'b00: result = a & b_eff;
         2'b01: result = a | b_eff;
         2'b10: result = sum;
         2'b11: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/mdu_seq.sv
// Iterative MULTU/DIVU sequencer. Borrows the shared ALU for 32 add or
// subtract steps and accumulates the result into HI/LO.
module mdu_seq
   import mips_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_cont,
   input  logic [WIDTH-1:0] alu_result
);

   mdu_state_t       state_q, state_d;
   mdu_op_t          op_q, op_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand or divisor
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] rem_shift;      // partial remainder shifted left by one
   logic             mul_carry;
   logic             div_ge;

   assign rem_shift = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
   assign mul_carry = add_carry(hi_q[WIDTH-1], opb_q[WIDTH-1], alu_result[WIDTH-1]);
   // The bit shifted out of hi means the remainder already exceeds any divisor.
   assign div_ge    = hi_q[WIDTH-1]
                    | add_carry(rem_shift[WIDTH-1], ~opb_q[WIDTH-1], alu_result[WIDTH-1]);

   // ALU operand drive; parked at 0+0 outside RUN so the bus never floats X.
   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_cont = ALU_ADD;
      if (state_q == RUN) begin
         if (op_q == MULTU) begin
            alu_a    = hi_q;
            alu_b    = opb_q;
            alu_cont = ALU_ADD;
         end else begin
            alu_a    = rem_shift;
            alu_b    = opb_q;
            alu_cont = ALU_SUB;
         end
      end
   end

   // Next-state and datapath step for one iteration.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      count_d = count_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      opb_d   = opb_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = mdu_op_t'(op);
               count_d = '0;
               hi_d    = '0;
               state_d = RUN;
               if (mdu_op_t'(op) == MULTU) begin
                  lo_d  = srcb;
                  opb_d = srca;
               end else begin
                  lo_d  = srca;
                  opb_d = srcb;
               end
            end
         end
         RUN: begin
            if (op_q == MULTU) begin
               if (lo_q[0]) begin
                  hi_d = {mul_carry, alu_result[WIDTH-1:1]};
                  lo_d = {alu_result[0], lo_q[WIDTH-1:1]};
               end else begin
                  hi_d = {1'b0, hi_q[WIDTH-1:1]};
                  lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
               end
            end else begin
               if (div_ge) begin
                  hi_d = alu_result;
                  lo_d = {lo_q[WIDTH-2:0], 1'b1};
               end else begin
                  hi_d = rem_shift;
                  lo_d = {lo_q[WIDTH-2:0], 1'b0};
               end
            end
            count_d = count_q + 1'b1;
            if (count_q == CNT_W'(WIDTH-1)) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // Single register bank for FSM state, datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= MULTU;
         count_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         opb_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         opb_q   <= opb_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq wired to mips_alu; results checked against plain
// 64-bit arithmetic and the 33-cycle done timing.
module tb_mdu_seq;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, op;
   logic [31:0] srca, srcb;
   logic        busy, done;
   logic [31:0] hi, lo, alu_a, alu_b, alu_result;
   logic [2:0]  alu_cont;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mdu_seq dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
      .busy(busy), .done(done), .hi(hi), .lo(lo),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont), .alu_result(alu_result)
   );

   mips_alu alu (.a(alu_a), .b(alu_b), .alucont(alu_cont), .result(alu_result));

   // Cycle k is the interval just after clock edge k; sample 1 time unit in.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: arithmetic product, or quotient/remainder with the
   // all-ones quotient / dividend remainder for a zero divisor.
   task automatic model(input bit o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] eh, output logic [31:0] el);
      logic [63:0] p;
      if (!o) begin
         p  = {32'b0, a} * {32'b0, b};
         eh = p[63:32];
         el = p[31:0];
      end else if (b == 0) begin
         eh = a;
         el = 32'hFFFF_FFFF;
      end else begin
         eh = a % b;
         el = a / b;
      end
   endtask

   // Launch one operation at cycle 0 and watch 36 cycles afterwards.
   task automatic run_op(input bit o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl,
                         output int dcyc, output int dcnt, output int busy_err);
      start = 1'b1; op = o; srca = a; srcb = b;
      tick();
      start = 1'b0;
      srca = $urandom; srcb = $urandom;
      dcyc = -1; dcnt = 0; busy_err = 0; rh = 'x; rl = 'x;
      for (int c = 1; c <= 36; c++) begin
         if (c > 1) tick();
         if (done) begin
            dcnt++;
            dcyc = c;
            rh = hi;
            rl = lo;
         end
         if ((c <= 33) != (busy === 1'b1)) busy_err++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; op = 1'b0; srca = '0; srcb = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
      n_checks++;
      if ({busy, done, hi, lo} !== 66'b0) begin
         n_fail++;
         $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
      end
      n_checks++;
      if (alu_a !== 32'b0 || alu_b !== 32'b0 || alu_cont !== ALU_ADD) begin
         n_fail++;
         $display("FAIL idle_alu a=%h b=%h cont=%b, required 0 0 010", alu_a, alu_b, alu_cont);
      end
   endtask

   // Directed operation: result value plus exact busy/done timing.
   task automatic test_directed(input string name, input bit o,
                                input logic [31:0] a, input logic [31:0] b);
      logic [31:0] rh, rl, eh, el;
      int dcyc, dcnt, berr;
      model(o, a, b, eh, el);
      run_op(o, a, b, rh, rl, dcyc, dcnt, berr);
      n_checks++;
      if (rh !== eh || rl !== el) begin
         n_fail++;
         $display("FAIL %s_result hi=%h lo=%h, required hi=%h lo=%h", name, rh, rl, eh, el);
      end
      n_checks++;
      if (dcyc != 33 || dcnt != 1 || berr != 0) begin
         n_fail++;
         $display("FAIL %s_timing done_cycle=%0d pulses=%0d busy_errs=%0d, required 33 1 0", name, dcyc, dcnt, berr);
      end
      n_checks++;
      if (hi !== eh || lo !== el) begin
         n_fail++;
         $display("FAIL %s_hold hi=%h lo=%h, required hi=%h lo=%h", name, hi, lo, eh, el);
      end
   endtask

   task automatic test_start_while_busy();
      int dcnt = 0;
      logic [31:0] rl = 'x;
      start = 1'b1; op = 1'b0; srca = 32'd3; srcb = 32'd5;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 45; c++) begin
         if (c > 1) tick();
         if (done) begin dcnt++; rl = lo; end
         // Re-pulse with a different divide request during cycles 5 and 33.
         start = (c == 5 || c == 33);
         op = 1'b1; srca = 32'd1000; srcb = 32'd9;
      end
      start = 1'b0;
      n_checks++;
      if (dcnt != 1 || rl !== 32'd15) begin
         n_fail++;
         $display("FAIL busy_start pulses=%0d lo=%h, required 1 0000000f", dcnt, rl);
      end
      n_checks++;
      if (busy !== 1'b0 || lo !== 32'd15 || hi !== 32'd0) begin
         n_fail++;
         $display("FAIL busy_start_after busy=%b hi=%h lo=%h, required 0 0 f", busy, hi, lo);
      end
   endtask

   task automatic test_reset_abort();
      int dcnt = 0;
      start = 1'b1; op = 1'b1; srca = 32'hDEAD_BEEF; srcb = 32'd17;
      tick();
      start = 1'b0;
      for (int c = 1; c < 11; c++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'b0 || lo !== 32'b0) begin
         n_fail++;
         $display("FAIL abort_state busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
      end
      for (int c = 0; c < 40; c++) begin
         tick();
         if (done) dcnt++;
      end
      n_checks++;
      if (dcnt != 0) begin
         n_fail++;
         $display("FAIL abort_no_done pulses=%0d, required 0", dcnt);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, rh, rl, eh, el;
      int dcyc, dcnt, berr;
      bit o;
      for (int i = 0; i < 24; i++) begin
         o = $urandom_range(0, 1);
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = $urandom_range(1, 15);
            1: b = a >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         model(o, a, b, eh, el);
         run_op(o, a, b, rh, rl, dcyc, dcnt, berr);
         n_checks++;
         if (rh !== eh || rl !== el || dcyc != 33 || dcnt != 1 || berr != 0) begin
            n_fail++;
            $display("FAIL random_%0d op=%0d a=%h b=%h hi=%h lo=%h done_cycle=%0d, required hi=%h lo=%h done_cycle=33",
                     i, o, a, b, rh, rl, dcyc, eh, el);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed("mul_7x6",     1'b0, 32'd7,           32'd6);
      test_directed("mul_max",     1'b0, 32'hFFFF_FFFF,   32'hFFFF_FFFF);
      test_directed("div_100_7",   1'b1, 32'd100,         32'd7);
      test_directed("div_msb_3",   1'b1, 32'h8000_0000,   32'd3);
      test_directed("div_zero",    1'b1, 32'h0000_1234,   32'd0);
      test_directed("div_max_max", 1'b1, 32'hFFFF_FFFF,   32'hFFFF_FFFF);
      test_start_while_busy();
      test_reset_abort();
      test_directed("mul_2p16",    1'b0, 32'h0001_0000,   32'h0001_0000);
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
